axi_lite_regs: RTL and testbench

AXI4-Lite slave register bank that terminates one slave port of the AXI-Lite crossbar. It decodes the in-page offset of each access and serves two register sets: NREG read/write control registers driven out to fabric logic, and NSTAT read-only status words sampled from fabric inputs. Write and read channels run independent handshake state machines. Every access completes with an OKAY, SLVERR or DECERR response.

---
 rtl/axi_lite_if.sv | 37 +++
 rtl/axi_lite_regs.sv | 180 ++++++++++++++++++
 tb/tb_axi_lite_regs.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle: aw/w/b/ar/r channels with master and slave views.
interface axi_lite_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arvalid, rready,
      output awready, wready, bresp, bvalid,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_regs.sv
// AXI4-Lite register bank: RW control words followed by RO status words.
// Write and read channels run as independent two-state machines.
module axi_lite_regs #(
   parameter int            NREG    = 8,
   parameter int            NSTAT   = 4,
   parameter int            LAW     = 12,
   parameter int            DW      = 32,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   axi_lite_if.slave                 s,
   output logic [NREG-1:0][DW-1:0]   ctrl,
   output logic [NREG-1:0]           ctrl_wr,
   input  logic [NSTAT-1:0][DW-1:0]  stat
);
   localparam int IW = LAW - 2;
   localparam int NB = DW / 8;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t        wst;
   rstate_t        rst;
   logic           aw_held;
   logic           w_held;
   logic [IW-1:0]  aw_idx;
   logic [DW-1:0]  w_data;
   logic [NB-1:0]  w_strb;
   logic           bvalid;
   logic [1:0]     bresp;
   logic           rvalid;
   logic [1:0]     rresp;
   logic [DW-1:0]  rdata;

   logic           aw_fire;
   logic           w_fire;
   logic           ar_fire;
   logic           commit;
   logic [IW-1:0]  widx;
   logic [DW-1:0]  wd;
   logic [NB-1:0]  ws;
   logic [IW-1:0]  ridx;
   logic [1:0]     w_resp;
   logic [NREG-1:0] w_hit;
   logic [DW-1:0]  rd_data;
   logic [1:0]     rd_resp;
   logic           unused_addr;

   assign unused_addr = ^{s.awaddr, s.araddr};

   assign s.awready = aresetn && wst == W_IDLE && !aw_held;
   assign s.wready  = aresetn && wst == W_IDLE && !w_held;
   assign s.arready = aresetn && rst == R_IDLE;
   assign s.bvalid  = bvalid;
   assign s.bresp   = bresp;
   assign s.rvalid  = rvalid;
   assign s.rresp   = rresp;
   assign s.rdata   = rdata;

   assign aw_fire = s.awvalid && s.awready;
   assign w_fire  = s.wvalid && s.wready;
   assign ar_fire = s.arvalid && s.arready;

   // A capture on this edge counts toward the commit.
   assign widx   = aw_held ? aw_idx : s.awaddr[LAW-1:2];
   assign wd     = w_held ? w_data : s.wdata;
   assign ws     = w_held ? w_strb : s.wstrb;
   assign commit = wst == W_IDLE && (aw_held || aw_fire)
                   && (w_held || w_fire);
   assign ridx   = s.araddr[LAW-1:2];

   always_comb begin
      w_resp = 2'b11;
      w_hit  = '0;
      for (int i = 0; i < NREG; i++) begin
         if (widx == IW'(i)) begin
            w_resp   = 2'b00;
            w_hit[i] = 1'b1;
         end
      end
      for (int j = 0; j < NSTAT; j++) begin
         if (widx == IW'(NREG + j)) w_resp = 2'b10;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_resp = 2'b11;
      for (int i = 0; i < NREG; i++) begin
         if (ridx == IW'(i)) begin
            rd_data = ctrl[i];
            rd_resp = 2'b00;
         end
      end
      for (int j = 0; j < NSTAT; j++) begin
         if (ridx == IW'(NREG + j)) begin
            rd_data = stat[j];
            rd_resp = 2'b00;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wst     <= W_IDLE;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_idx  <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         bvalid  <= 1'b0;
         bresp   <= 2'b00;
         ctrl_wr <= '0;
         ctrl    <= {NREG{RST_VAL}};
      end else begin
         ctrl_wr <= '0;
         unique case (wst)
            W_IDLE: begin
               if (commit) begin
                  for (int i = 0; i < NREG; i++) begin
                     for (int k = 0; k < NB; k++) begin
                        if (w_hit[i] && ws[k])
                           ctrl[i][8*k +: 8] <= wd[8*k +: 8];
                     end
                  end
                  ctrl_wr <= w_hit;
                  bresp   <= w_resp;
                  bvalid  <= 1'b1;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  wst     <= W_RESP;
               end else begin
                  if (aw_fire) begin
                     aw_held <= 1'b1;
                     aw_idx  <= s.awaddr[LAW-1:2];
                  end
                  if (w_fire) begin
                     w_held <= 1'b1;
                     w_data <= s.wdata;
                     w_strb <= s.wstrb;
                  end
               end
            end
            W_RESP: begin
               if (s.bready) begin
                  bvalid <= 1'b0;
                  wst    <= W_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rst    <= R_IDLE;
         rvalid <= 1'b0;
         rresp  <= 2'b00;
         rdata  <= '0;
      end else begin
         unique case (rst)
            R_IDLE: begin
               if (ar_fire) begin
                  rdata  <= rd_data;
                  rresp  <= rd_resp;
                  rvalid <= 1'b1;
                  rst    <= R_DATA;
               end
            end
            R_DATA: begin
               if (s.rready) begin
                  rvalid <= 1'b0;
                  rst    <= R_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_regs.sv
// Bench for axi_lite_regs: expected B/R responses are queued at issue
// and matched when the handshake is seen.
module tb_axi_lite_regs;
   logic             aclk;
   logic             aresetn;
   logic [7:0][31:0] ctrl;
   logic [7:0]       ctrl_wr;
   logic [3:0][31:0] stat;

   axi_lite_if #(.AW(32), .DW(32)) s ();

   axi_lite_regs #(
      .NREG(8), .NSTAT(4), .LAW(12), .DW(32), .RST_VAL(32'h0)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .s(s.slave),
      .ctrl(ctrl),
      .ctrl_wr(ctrl_wr),
      .stat(stat)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   logic [1:0]  bexp [$];
   logic [33:0] rexp [$];
   logic [31:0] mdl [8];

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(negedge aclk) begin
      if (aresetn && s.bvalid && s.bready) begin
         if (bexp.size() == 0) check("b_unexpected", 1, 0);
         else check("bresp", 64'(s.bresp), 64'(bexp.pop_front()));
      end
      if (aresetn && s.rvalid && s.rready) begin
         if (rexp.size() == 0) check("r_unexpected", 1, 0);
         else check("rresp_rdata", 64'({s.rresp, s.rdata}),
                    64'(rexp.pop_front()));
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] st, input logic [1:0] er);
      logic aw_ok, w_ok;
      int   idx;
      bexp.push_back(er);
      if (er == 2'b00) begin
         idx = int'(a[11:2]);
         for (int k = 0; k < 4; k++)
            if (st[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
      end
      @(posedge aclk) #1;
      s.awaddr = a; s.awvalid = 1'b1;
      s.wdata = d; s.wstrb = st; s.wvalid = 1'b1;
      for (int n = 0; n < 20 && (s.awvalid || s.wvalid); n++) begin
         @(negedge aclk);
         aw_ok = s.awready; w_ok = s.wready;
         @(posedge aclk) #1;
         if (aw_ok) s.awvalid = 1'b0;
         if (w_ok) s.wvalid = 1'b0;
      end
      if (s.awvalid || s.wvalid) begin
         check("wr_timeout", 1, 0);
         s.awvalid = 1'b0; s.wvalid = 1'b0;
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] ed,
                     input logic [1:0] er);
      logic ar_ok;
      rexp.push_back({er, ed});
      @(posedge aclk) #1;
      s.araddr = a; s.arvalid = 1'b1;
      for (int n = 0; n < 20 && s.arvalid; n++) begin
         @(negedge aclk);
         ar_ok = s.arready;
         @(posedge aclk) #1;
         if (ar_ok) s.arvalid = 1'b0;
      end
      if (s.arvalid) begin
         check("rd_timeout", 1, 0);
         s.arvalid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && (bexp.size() != 0 || rexp.size() != 0); n++)
         @(posedge aclk);
      #1;
      check("b_pending", 64'(bexp.size()), 0);
      check("r_pending", 64'(rexp.size()), 0);
   endtask

   task automatic check_ctrl();
      for (int i = 0; i < 8; i++) check("ctrl_model", ctrl[i], mdl[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 want 0");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] old;
      aresetn = 1'b0;
      s.awaddr = '0; s.awvalid = 1'b0;
      s.wdata = '0; s.wstrb = '0; s.wvalid = 1'b0;
      s.bready = 1'b1;
      s.araddr = '0; s.arvalid = 1'b0;
      s.rready = 1'b1;
      stat = '0;
      for (int i = 0; i < 8; i++) mdl[i] = 32'h0;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_awready", s.awready, 0);
      check("rst_arready", s.arready, 0);
      check("rst_bvalid", s.bvalid, 0);
      check("rst_rvalid", s.rvalid, 0);
      check("rst_ctrl_wr", ctrl_wr, 0);
      check_ctrl();
      @(posedge aclk) #1;
      aresetn = 1'b1;
      @(negedge aclk);
      check("post_rst_awready", s.awready, 1);
      check("post_rst_wready", s.wready, 1);
      check("post_rst_arready", s.arready, 1);
      check("post_rst_bvalid", s.bvalid, 0);
      check("post_rst_rdata", s.rdata, 0);
      check("post_rst_rresp", s.rresp, 0);
      check("post_rst_bresp", s.bresp, 0);

      wr(32'h004, 32'hDEADBEEF, 4'hF, 2'b00);
      check("wr1_bvalid", s.bvalid, 1);
      check("wr1_ctrl_wr", ctrl_wr, 8'b0000_0010);
      check("wr1_ctrl", ctrl[1], 32'hDEADBEEF);
      @(posedge aclk) #1;
      check("wr1_ctrl_wr_drop", ctrl_wr, 0);
      rd(32'h004, 32'hDEADBEEF, 2'b00);
      check("rd1_rvalid", s.rvalid, 1);
      rd(32'h007, 32'hDEADBEEF, 2'b00);
      rd(32'h1004, 32'hDEADBEEF, 2'b00);
      drain();

      wr(32'h008, 32'h11223344, 4'hF, 2'b00);
      drain();
      bexp.push_back(2'b00);
      @(posedge aclk) #1;
      s.wdata = 32'hAABBCCDD; s.wstrb = 4'b0101; s.wvalid = 1'b1;
      @(negedge aclk);
      check("wfirst_wready", s.wready, 1);
      @(posedge aclk) #1;
      s.wvalid = 1'b0;
      repeat (2) begin
         @(negedge aclk);
         check("wfirst_wready_held", s.wready, 0);
         check("wfirst_no_bvalid", s.bvalid, 0);
         @(posedge aclk) #1;
      end
      s.awaddr = 32'h008; s.awvalid = 1'b1;
      @(negedge aclk);
      check("wfirst_awready", s.awready, 1);
      @(posedge aclk) #1;
      s.awvalid = 1'b0;
      mdl[2] = 32'h11BB33DD;
      check("wfirst_bvalid", s.bvalid, 1);
      check("wfirst_ctrl", ctrl[2], 32'h11BB33DD);
      check("wfirst_ctrl_wr", ctrl_wr, 8'b0000_0100);
      drain();

      wr(32'h004, 32'h12345678, 4'h0, 2'b00);
      check("strb0_ctrl_wr", ctrl_wr, 8'b0000_0010);
      check("strb0_ctrl", ctrl[1], 32'hDEADBEEF);
      drain();

      stat[0] = 32'h0000CAFE;
      stat[3] = 32'h5A5A0003;
      rd(32'h020, 32'h0000CAFE, 2'b00);
      rd(32'h02C, 32'h5A5A0003, 2'b00);
      wr(32'h020, 32'hFFFFFFFF, 4'hF, 2'b10);
      check("stat_wr_ctrl_wr", ctrl_wr, 0);
      drain();
      check_ctrl();
      rd(32'h020, 32'h0000CAFE, 2'b00);

      rd(32'h0FC, 32'h0, 2'b11);
      rd(32'h030, 32'h0, 2'b11);
      wr(32'h0FC, 32'hFFFFFFFF, 4'hF, 2'b11);
      check("unmap_ctrl_wr", ctrl_wr, 0);
      wr(32'h030, 32'hFFFFFFFF, 4'hF, 2'b11);
      drain();
      check_ctrl();

      s.bready = 1'b0; s.rready = 1'b0;
      old = mdl[2];
      fork
         wr(32'h008, 32'h0F0F0F0F, 4'hF, 2'b00);
         rd(32'h008, old, 2'b00);
      join
      check("hold_ctrl_new", ctrl[2], 32'h0F0F0F0F);
      repeat (5) begin
         @(negedge aclk);
         check("hold_bvalid", s.bvalid, 1);
         check("hold_rvalid", s.rvalid, 1);
         check("hold_bresp", s.bresp, 2'b00);
         check("hold_rdata_old", s.rdata, old);
         check("hold_awready", s.awready, 0);
         check("hold_wready", s.wready, 0);
         check("hold_arready", s.arready, 0);
      end
      @(posedge aclk) #1;
      s.bready = 1'b1; s.rready = 1'b1;
      @(posedge aclk) #1;
      check("rel_bvalid", s.bvalid, 0);
      check("rel_rvalid", s.rvalid, 0);
      check("rel_awready", s.awready, 1);
      check("rel_arready", s.arready, 1);
      drain();
      rd(32'h008, 32'h0F0F0F0F, 2'b00);
      drain();

      s.bready = 1'b0;
      wr(32'h000, 32'h00000005, 4'hF, 2'b00);
      check("mid_bvalid", s.bvalid, 1);
      check("mid_ctrl0", ctrl[0], 32'h5);
      aresetn = 1'b0;
      @(posedge aclk) #1;
      check("mid_rst_bvalid", s.bvalid, 0);
      check("mid_rst_ctrl0", ctrl[0], 32'h0);
      check("mid_rst_awready", s.awready, 0);
      bexp.delete();
      for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
      check_ctrl();
      aresetn = 1'b1;
      s.bready = 1'b1;
      wr(32'h000, 32'h00000077, 4'hF, 2'b00);
      check("after_rst_ctrl_wr", ctrl_wr, 8'b0000_0001);
      rd(32'h000, 32'h00000077, 2'b00);
      drain();
      check_ctrl();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
